dct2_8_tbuf: RTL and testbench

- 8x8 transpose buffer between the first-stage (row) 8-point DCT-II and the second-stage (column) 8-point DCT-II in the 2-D transform.
- Accepts one 8-sample row per handshake from the row pass and emits one 8-sample column per handshake, ready to feed the column pass's X[0:7] input.
- Ping-pong, two 8x8 register banks: one block fills while the other drains, so sustained throughput is one row in and one column out per cycle.

---
 rtl/dct2_8_tbuf.sv | 123 ++++++++++++
 tb/tb_dct2_8_tbuf.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct2_8_tbuf.sv
// ----------------------------------------------------------------------------
// dct2_8_tbuf
//
// 8x8 transpose buffer sitting between the row pass and the column pass of
// the 2-D 8-point DCT-II. Rows from the row pass are written into one of two
// register banks. Once a bank holds a complete block it is read back one
// column at a time. The two banks ping-pong, so one block can fill while the
// other drains. Sustained throughput is one row in and one column out per
// cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   in_row carries a valid row
//   in_ready   a row can be accepted this cycle
//   in_row     8 signed W-bit samples, index = column position
//   out_valid  out_col carries a valid column
//   out_ready  consumer takes the column this cycle
//   out_col    8 signed W-bit samples, index = row position
//   out_idx    column index (0..7) of the column on out_col
//   out_last   high together with column 7 of a block
// ----------------------------------------------------------------------------
module dct2_8_tbuf #(
    parameter int W = 18,
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_row [0:N-1],
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_col [0:N-1],
    output logic [2:0]          out_idx,
    output logic                out_last
);

    localparam logic [2:0] LAST_IDX = 3'd7;

    // Two banks of 8x8 samples, indexed [row][column].
    logic signed [W-1:0] bank0 [0:N-1][0:N-1];
    logic signed [W-1:0] bank1 [0:N-1][0:N-1];

    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
    logic [2:0] wr_cnt;
    logic [2:0] rd_cnt;

    logic       wr_fire;
    logic       rd_fire;

    // The handshake qualifiers depend only on registered state. The upstream
    // and downstream stages can therefore look at ready/valid without forming
    // a combinational loop through this block.
    always_comb begin
        in_ready  = !full[wr_bank];
        out_valid = full[rd_bank];
        wr_fire   = in_valid && in_ready;
        rd_fire   = out_valid && out_ready;
    end

    // Control state: fill/drain pointers and the per-bank full flags. A fill
    // completion and a drain completion can fall on the same edge. The fill
    // always targets the bank that is not full, and the drain targets the
    // bank that is full, so the two flag writes never touch the same bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= 3'd0;
            rd_cnt  <= 3'd0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 3'd1;
                if (wr_cnt == LAST_IDX) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 3'd1;
                if (rd_cnt == LAST_IDX) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                end
            end
        end
    end

    // Sample storage. This block is deliberately left out of the reset.
    // Stale contents are harmless because a bank is only read after its
    // full flag is set, and the full flag is set only after all 64 samples
    // of the current block have been written.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int c = 0; c < N; c++) begin
                if (wr_bank) begin
                    bank1[wr_cnt][c] <= in_row[c];
                end else begin
                    bank0[wr_cnt][c] <= in_row[c];
                end
            end
        end
    end

    // Column read-out. All eight row entries of column rd_cnt are picked in
    // parallel from the draining bank. When nothing is valid, the outputs
    // are forced to zero so that stale bank data never leaks downstream.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            out_col[r] = '0;
            if (out_valid) begin
                out_col[r] = rd_bank ? bank1[r][rd_cnt] : bank0[r][rd_cnt];
            end
        end
        out_idx  = out_valid ? rd_cnt : 3'd0;
        out_last = out_valid && (rd_cnt == LAST_IDX);
    end

endmodule

// File: tb/tb_dct2_8_tbuf.sv
// ----------------------------------------------------------------------------
// tb_dct2_8_tbuf
//
// Bench for the 8x8 transpose buffer. A reference model holds each completed
// block as a flat row-major list of samples. It treats the buffer as a
// two-block FIFO that is drained column by column. A compare process checks
// every output of the DUT against that model on each falling edge. A set of
// hand-computed literal expectations pins the model itself.
// ----------------------------------------------------------------------------
module tb_dct2_8_tbuf;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [17:0]  in_row [0:7];
    logic                out_valid;
    logic                out_ready;
    logic signed [17:0]  out_col [0:7];
    logic [2:0]          out_idx;
    logic                out_last;

    int total;
    int bad;
    int cyc;
    bit chk_en;

    // Reference model state: completed blocks waiting to drain, the block
    // being filled, and the column of the front block currently presented.
    logic signed [17:0] done_q [$];
    logic signed [17:0] cur_q [$];
    int m_col;
    int rows_in;
    int blocks_out;

    dct2_8_tbuf #(.W(18), .N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, used to measure latency.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model update on each rising edge. The handshakes are judged from the
    // model's own idea of ready/valid: at most two complete blocks can be
    // held, and output is valid whenever at least one complete block exists.
    always @(posedge clk) begin
        bit wr;
        bit rd;
        if (!rst_n) begin
            done_q.delete();
            cur_q.delete();
            m_col = 0;
        end else begin
            wr = in_valid && (done_q.size() < 128);
            rd = out_ready && (done_q.size() >= 64);
            if (rd) begin
                if (m_col == 7) begin
                    for (int i = 0; i < 64; i++) void'(done_q.pop_front());
                    m_col = 0;
                    blocks_out++;
                end else begin
                    m_col++;
                end
            end
            if (wr) begin
                for (int c = 0; c < 8; c++) cur_q.push_back(in_row[c]);
                rows_in++;
                if (cur_q.size() == 64) begin
                    foreach (cur_q[i]) done_q.push_back(cur_q[i]);
                    cur_q.delete();
                end
            end
        end
    end

    // Compare process: on every falling edge after the first reset, each
    // DUT output is checked against the model.
    always @(negedge clk) begin
        bit                 ev;
        bit                 er;
        logic signed [17:0] ec;
        bit                 col_ok;
        int                 bad_r;
        if (chk_en) begin
            ev = (done_q.size() >= 64);
            er = (done_q.size() < 128);
            total++;
            if (out_valid !== ev) begin
                bad++;
                $display("[TB] FAIL out_valid t=%0t got=%b want=%b", $time, out_valid, ev);
            end
            total++;
            if (in_ready !== er) begin
                bad++;
                $display("[TB] FAIL in_ready t=%0t got=%b want=%b", $time, in_ready, er);
            end
            total++;
            if (out_idx !== (ev ? 3'(m_col) : 3'd0)) begin
                bad++;
                $display("[TB] FAIL out_idx t=%0t got=%0d want=%0d", $time, out_idx, ev ? m_col : 0);
            end
            total++;
            if (out_last !== (ev && m_col == 7)) begin
                bad++;
                $display("[TB] FAIL out_last t=%0t got=%b want=%b", $time, out_last, ev && m_col == 7);
            end
            col_ok = 1'b1;
            bad_r  = 0;
            for (int r = 0; r < 8; r++) begin
                ec = ev ? done_q[r*8 + m_col] : 18'sd0;
                if (out_col[r] !== ec && col_ok) begin
                    col_ok = 1'b0;
                    bad_r  = r;
                end
            end
            total++;
            if (!col_ok) begin
                bad++;
                ec = ev ? done_q[bad_r*8 + m_col] : 18'sd0;
                $display("[TB] FAIL out_col[%0d] t=%0t got=%0d want=%0d", bad_r, $time, out_col[bad_r], ec);
            end
        end
    end

    // Literal comparison against a hand-computed value.
    task automatic checkOutput(input string name, input logic signed [31:0] act,
                               input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Drives the handshake-side controls just after a rising edge.
    task automatic applyStimulus(input logic iv, input logic ordy);
        in_valid  = iv;
        out_ready = ordy;
    endtask

    // Sample generator. Kind 0 is base+8r+c. Kind 1 alternates between the
    // signed extremes. Any other kind gives a random 18-bit value.
    function automatic int rowVal(input int kind, input int base, input int r, input int c);
        if (kind == 0) return base + 8*r + c;
        if (kind == 1) return ((r + c) % 2 == 0) ? -131072 : 131071;
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    // Presents one row and waits, with a bound, until it is accepted.
    // Returns the number of edges that were needed.
    task automatic sendRow(input int kind, input int base, input int r, output int edges);
        logic rdy;
        for (int c = 0; c < 8; c++) in_row[c] = 18'(rowVal(kind, base, r, c));
        in_valid = 1'b1;
        edges = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            edges++;
        end while (!rdy && edges < 200);
        #1;
        if (!rdy) begin
            bad++;
            total++;
            $display("[TB] FAIL row_accept timeout got=0 want=1");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e;
        int acc;
        int stalls;
        int t0;
        int t1;
        int vcnt;
        int n;
        int target;
        logic rdy17;

        total = 0; bad = 0; chk_en = 0;
        m_col = 0; rows_in = 0; blocks_out = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        for (int c = 0; c < 8; c++) in_row[c] = '0;
        idle(3);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state.
        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_idx", out_idx, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_out_col0", out_col[0], 0);
        @(posedge clk); #1;

        // Single block with sample value 8r+c and the consumer always ready.
        $display("[TB] single block");
        applyStimulus(1'b0, 1'b1);
        for (int r = 0; r < 8; r++) sendRow(0, 0, r, e);
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput("single_valid", out_valid, 1);
            checkOutput("single_idx", out_idx, c);
            checkOutput("single_diag", out_col[c], 9*c);
            checkOutput("single_row7", out_col[7], 56 + c);
            checkOutput("single_last", out_last, (c == 7) ? 1 : 0);
        end
        @(negedge clk);
        checkOutput("single_drained", out_valid, 0);
        @(posedge clk); #1;

        // Signed extremes, transposed without corruption.
        $display("[TB] extremes");
        for (int r = 0; r < 8; r++) sendRow(1, 0, r, e);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("ext_r0", out_col[0], -131072);
        checkOutput("ext_r1", out_col[1], 131071);
        idle(10);

        // Backpressure: two blocks are absorbed and the 17th row is held off.
        $display("[TB] backpressure");
        applyStimulus(1'b0, 1'b0);
        acc = 0;
        rdy17 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            for (int c = 0; c < 8; c++) in_row[c] = 18'((i < 8 ? 1000 : 2000) + 8*(i % 8) + c);
            in_valid = 1'b1;
            @(negedge clk);
            if (i < 16 && in_ready) acc++;
            if (i == 16) rdy17 = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("bp_accepted", acc, 16);
        checkOutput("bp_ready17", rdy17, 0);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_firstA", out_col[0], 1000);
        for (int i = 0; i < 7; i++) @(negedge clk);
        checkOutput("bp_hold_ready", in_ready, 0);
        checkOutput("bp_lastA", out_last, 1);
        @(negedge clk);
        checkOutput("bp_ready_back", in_ready, 1);
        checkOutput("bp_firstB", out_col[0], 2000);
        idle(10);

        // Streaming: four back-to-back blocks with no gaps.
        $display("[TB] streaming");
        stalls = 0; t0 = 0; t1 = 0; vcnt = 0;
        fork
            begin
                for (int r = 0; r < 32; r++) begin
                    sendRow(0, 100*(r/8 + 1), r % 8, e);
                    if (r == 0) t0 = cyc;
                    if (e > 1) stalls++;
                end
                in_valid = 1'b0;
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 100);
                t1 = cyc;
                for (int i = 0; i < 32; i++) begin
                    if (out_valid) vcnt++;
                    @(negedge clk);
                end
            end
        join
        checkOutput("stream_stalls", stalls, 0);
        checkOutput("stream_latency", t1 - t0, 7);
        checkOutput("stream_gapless", vcnt, 32);
        idle(4);

        // Random valid/ready over 20 blocks; the compare process does the work.
        $display("[TB] random");
        target = blocks_out + 20;
        n = rows_in + 160;
        for (int i = 0; i < 4000 && rows_in < n; i++) begin
            for (int c = 0; c < 8; c++) in_row[c] = 18'(rowVal(2, 0, 0, c));
            applyStimulus((rows_in < n) ? 1'($urandom % 2) : 1'b0, 1'($urandom % 2));
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 200 && blocks_out < target; i++) idle(1);
        checkOutput("rand_done", (blocks_out >= target) ? 1 : 0, 1);

        // Reset while one block drains and another is half filled.
        $display("[TB] mid-operation reset");
        applyStimulus(1'b0, 1'b0);
        for (int r = 0; r < 8; r++) sendRow(0, 5000, r, e);
        for (int r = 0; r < 5; r++) sendRow(0, 6000, r, e);
        applyStimulus(1'b0, 1'b1);
        idle(3);
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("mid_colA", out_idx, 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) sendRow(0, 7000, r, e);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("fresh_valid", out_valid, 1);
        checkOutput("fresh_idx", out_idx, 0);
        checkOutput("fresh_col", out_col[2], 7016);
        for (int i = 0; i < 8; i++) @(negedge clk);
        checkOutput("fresh_nodiscard", out_valid, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
